conv_window_gen: RTL and testbench

CONV_WINDOW_GEN -- requirements
Module: conv_window_gen

---
 rtl/conv_window_gen_pkg.sv | 16 +
 rtl/conv_window_gen_line_buffer.sv | 33 +++
 rtl/conv_window_gen.sv | 143 ++++++++++++++
 tb/tb_conv_window_gen.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_window_gen_pkg.sv
// Shared CNN package: default pixel width and filter edge, plus the
// row-major patch index helper used by both the window generator and the
// convolution unit so their flattened image/filter buses agree.
//   CNN_DATA_WIDTH : default width of one pixel word
//   CNN_F          : default filter / window edge size
//   win_idx(r,c,f) : flat element index of patch element (r,c) = r*f + c
package conv_window_gen_pkg;

    localparam int CNN_DATA_WIDTH = 32;
    localparam int CNN_F          = 5;

    function automatic int win_idx(input int r, input int c, input int f);
        return r * f + c;
    endfunction

endpackage

// File: rtl/conv_window_gen_line_buffer.sv
// line_buffer: DEPTH-deep shift FIFO of DATA_WIDTH words. One word enters
// and the oldest word leaves every cycle shift_en is high, so dout is the
// word pushed DEPTH shifts ago (the pixel one image row above).
//   clk      : clock
//   shift_en : advance the FIFO by one word
//   din      : word pushed on a shift
//   dout     : oldest word (DEPTH shifts old)
module line_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 32
) (
    input  logic                  clk,
    input  logic                  shift_en,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // NOTE: the storage array has no reset; a valid window never uses a word
    // that was not written in the current frame, so clearing it is wasted logic.
    always_ff @(posedge clk) begin
        if (shift_en) begin
            mem[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                mem[i] <= mem[i-1];
            end
        end
    end

    assign dout = mem[DEPTH-1];

endmodule

// File: rtl/conv_window_gen.sv
// conv_window_gen: turns a raster-order pixel stream into stride-1,
// unpadded F x F patches for a convolution unit.
//   clk          : sole clock, rising edge
//   reset        : synchronous, active-low
//   pixel_in     : pixel word, row-major, top-left first
//   pixel_valid  : pixel_in holds a pixel
//   pixel_ready  : pixel accepted this cycle if pixel_valid
//   window       : flattened patch, element (r,c) at DATA_WIDTH*(r*F+c)
//   window_valid : window holds a complete patch
//   window_ready : downstream consumes window this cycle
//   frame_done   : one-cycle pulse after the frame's last window is consumed
module conv_window_gen
    import conv_window_gen_pkg::*;
#(
    parameter int DATA_WIDTH = CNN_DATA_WIDTH,
    parameter int F          = CNN_F,
    parameter int W          = 32,
    parameter int H          = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [DATA_WIDTH-1:0]     pixel_in,
    input  logic                      pixel_valid,
    output logic                      pixel_ready,
    output logic [F*F*DATA_WIDTH-1:0] window,
    output logic                      window_valid,
    input  logic                      window_ready,
    output logic                      frame_done
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam int RW = (H > 1) ? $clog2(H) : 1;

    localparam logic [CW-1:0] COL_LAST  = CW'(W - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(H - 1);
    localparam logic [CW-1:0] COL_FIRST = CW'(F - 1);
    localparam logic [RW-1:0] ROW_FIRST = RW'(F - 1);

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          last_win;   // the pending window is the frame's final one

    logic [DATA_WIDTH-1:0] win      [F][F];
    logic [DATA_WIDTH-1:0] lb_in    [F-1];
    logic [DATA_WIDTH-1:0] lb_out   [F-1];
    logic [DATA_WIDTH-1:0] col_data [F];

    logic accept;
    logic completes;
    logic at_last;

    // A pending, unconsumed window freezes the whole pipeline.
    assign pixel_ready = !(window_valid && !window_ready);
    assign accept      = pixel_valid && pixel_ready;
    // Only full-height, full-width positions of the current row make a patch,
    // which also keeps previous-frame line-buffer data out of every window.
    assign completes   = accept && (row >= ROW_FIRST) && (col >= COL_FIRST);
    assign at_last     = (row == ROW_LAST) && (col == COL_LAST);

    // Line buffers are chained: buffer i outputs the pixel i+1 rows above.
    // NOTE: every variable driven in always_comb gets a value on every path
    // (defaults first); otherwise synthesis infers a latch.
    always_comb begin
        lb_in[0] = pixel_in;
        for (int i = 1; i < F - 1; i++) begin
            lb_in[i] = lb_out[i-1];
        end
    end

    for (genvar i = 0; i < F - 1; i++) begin : g_lb
        line_buffer #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (W)
        ) u_lb (
            .clk      (clk),
            .shift_en (accept),
            .din      (lb_in[i]),
            .dout     (lb_out[i])
        );
    end

    // New right-hand column of the window: oldest row on top, new pixel at bottom.
    always_comb begin
        col_data[F-1] = pixel_in;
        for (int r = 0; r < F - 1; r++) begin
            col_data[r] = lb_out[F-2-r];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            col          <= '0;
            row          <= '0;
            window_valid <= 1'b0;
            frame_done   <= 1'b0;
            last_win     <= 1'b0;
            for (int r = 0; r < F; r++) begin
                for (int c = 0; c < F; c++) begin
                    win[r][c] <= '0;
                end
            end
        end else begin
            frame_done <= window_valid && window_ready && last_win;

            if (accept) begin
                for (int r = 0; r < F; r++) begin
                    for (int c = 0; c < F - 1; c++) begin
                        win[r][c] <= win[r][c+1];
                    end
                    win[r][F-1] <= col_data[r];
                end

                if (col == COL_LAST) begin
                    col <= '0;
                    row <= (row == ROW_LAST) ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end

            // A completing pixel in the consume cycle keeps valid high
            // with the fresh patch (one window per cycle).
            if (completes) begin
                window_valid <= 1'b1;
                last_win     <= at_last;
            end else if (window_ready) begin
                window_valid <= 1'b0;
            end
        end
    end

    always_comb begin
        window = '0;
        for (int r = 0; r < F; r++) begin
            for (int c = 0; c < F; c++) begin
                window[DATA_WIDTH*win_idx(r, c, F) +: DATA_WIDTH] = win[r][c];
            end
        end
    end

endmodule

// File: tb/tb_conv_window_gen.sv
// Testbench for conv_window_gen. One instance with W=H=5 checked against
// hand-computed literals; one with W=H=6 checked every cycle against an
// image-level model of the expected window sequence.
module tb_conv_window_gen;

    localparam int DW = 32;
    localparam int FF = 5;
    localparam int WB = FF * FF * DW;
    localparam int N6 = 6;

    int checks   = 0;
    int failures = 0;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    // 5x5 instance
    logic [DW-1:0] pin5 = '0;
    logic          pv5  = 1'b0;
    logic          pr5;
    logic [WB-1:0] win5;
    logic          wv5;
    logic          wr5  = 1'b1;
    logic          fd5;

    // 6x6 instance
    logic [DW-1:0] pin6 = '0;
    logic          pv6  = 1'b0;
    logic          pr6;
    logic [WB-1:0] win6;
    logic          wv6;
    logic          wr6  = 1'b1;
    logic          fd6;

    conv_window_gen #(.DATA_WIDTH(DW), .F(FF), .W(5), .H(5)) dut5 (
        .clk          (clk),
        .reset        (reset),
        .pixel_in     (pin5),
        .pixel_valid  (pv5),
        .pixel_ready  (pr5),
        .window       (win5),
        .window_valid (wv5),
        .window_ready (wr5),
        .frame_done   (fd5)
    );

    conv_window_gen #(.DATA_WIDTH(DW), .F(FF), .W(N6), .H(N6)) dut6 (
        .clk          (clk),
        .reset        (reset),
        .pixel_in     (pin6),
        .pixel_valid  (pv6),
        .pixel_ready  (pr6),
        .window       (win6),
        .window_valid (wv6),
        .window_ready (wr6),
        .frame_done   (fd6)
    );

    task automatic check(input string name, input logic [WB-1:0] act, input logic [WB-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: expected windows of the 6x6 instance, in consumption order.
    logic [WB-1:0] exp_q[$];
    bit            exp_last[$];
    logic [DW-1:0] tl_log[$];

    task automatic push_frame(input int base);
        logic [WB-1:0] w;
        for (int r = FF - 1; r < N6; r++) begin
            for (int c = FF - 1; c < N6; c++) begin
                w = '0;
                for (int i = 0; i < FF; i++) begin
                    for (int j = 0; j < FF; j++) begin
                        w[DW*(i*FF+j) +: DW] = DW'(base + (r - FF + 1 + i) * N6 + (c - FF + 1 + j));
                    end
                end
                exp_q.push_back(w);
                exp_last.push_back(r == N6 - 1 && c == N6 - 1);
            end
        end
    endtask

    // Compare process: sampled mid-cycle after stimulus has settled.
    initial begin
        bit            prev_last = 1'b0;
        logic [WB-1:0] w;
        bit            l;
        forever begin
            @(negedge clk);
            #2;
            check("frame_done6", WB'(fd6), WB'(prev_last));
            prev_last = 1'b0;
            if (reset && wv6 && wr6) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_window", WB'(1), WB'(0));
                end else begin
                    w = exp_q.pop_front();
                    l = exp_last.pop_front();
                    check("window6", win6, w);
                    tl_log.push_back(win6[DW-1:0]);
                    prev_last = l;
                end
            end
        end
    end

    task automatic send(input int base, input int n, input bit rnd, input int stall);
        int            idx = 0;
        int            cyc = 0;
        int            stall_left = stall;
        bit            cap = 1'b0;
        logic [WB-1:0] held = '0;
        while (idx < n && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (stall_left > 0 && wv6) begin
                wr6 = 1'b0;
                if (!cap) begin
                    held = win6;
                    cap  = 1'b1;
                end else begin
                    check("stall_window", win6, held);
                end
                stall_left--;
            end else begin
                wr6 = 1'b1;
            end
            pv6  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            pin6 = DW'(base + idx);
            #1;
            if (!wr6) check("stall_ready", WB'(pr6), WB'(0));
            if (pv6 && pr6) idx++;
        end
        if (idx < n) check("send_timeout", WB'(idx), WB'(n));
        @(negedge clk);
        pv6 = 1'b0;
        wr6 = 1'b1;
    endtask

    task automatic drain();
        int k = 0;
        while (exp_q.size() != 0 && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("drain", WB'(exp_q.size()), WB'(0));
        repeat (3) @(negedge clk);
    endtask

    task automatic check_tl(input int base, input int start);
        int off[4] = '{0, 1, 6, 7};
        for (int i = 0; i < 4; i++) begin
            if (start + i < tl_log.size())
                check("top_left", WB'(tl_log[start+i]), WB'(base + off[i]));
            else
                check("top_left_missing", WB'(0), WB'(1));
        end
    endtask

    initial begin
        // Reset
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst_wv5", WB'(wv5), WB'(0));
        check("rst_fd5", WB'(fd5), WB'(0));
        check("rst_pr5", WB'(pr5), WB'(1));
        check("rst_win5", win5, WB'(0));
        check("rst_wv6", WB'(wv6), WB'(0));
        check("rst_pr6", WB'(pr6), WB'(1));
        check("rst_win6", win6, WB'(0));

        // 5x5 frame of 1..25: single window, element k = k+1
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(negedge clk);
            pv5  = (cyc < 25);
            pin5 = DW'(cyc + 1);
            #1;
            check("wv5", WB'(wv5), WB'(cyc == 25));
            check("fd5", WB'(fd5), WB'(cyc == 26));
            check("pr5", WB'(pr5), WB'(1));
            if (cyc == 25) begin
                for (int k = 0; k < FF * FF; k++) begin
                    check("win5_elem", WB'(win5[DW*k +: DW]), WB'(k + 1));
                end
            end
        end
        pv5 = 1'b0;

        // 6x6 frame 0..35
        push_frame(0);
        tl_log.delete();
        send(0, 36, 1'b0, 0);
        drain();
        check("tl_count", WB'(tl_log.size()), WB'(4));
        check_tl(0, 0);

        // Same frame with a 10-cycle stall on the first window
        push_frame(0);
        tl_log.delete();
        send(0, 36, 1'b0, 10);
        drain();
        check("tl_count_stall", WB'(tl_log.size()), WB'(4));
        check_tl(0, 0);

        // Two frames back-to-back
        push_frame(0);
        push_frame(100);
        tl_log.delete();
        send(0, 36, 1'b0, 0);
        send(100, 36, 1'b0, 0);
        drain();
        check("tl_count_2f", WB'(tl_log.size()), WB'(8));
        check_tl(0, 0);
        check_tl(100, 4);

        // Reset mid-frame after 20 pixels, then a full frame
        tl_log.delete();
        send(50, 20, 1'b0, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        push_frame(0);
        send(0, 36, 1'b0, 0);
        drain();
        check("tl_count_rst", WB'(tl_log.size()), WB'(4));
        check_tl(0, 0);

        // Randomly gapped pixel_valid
        push_frame(0);
        tl_log.delete();
        send(0, 36, 1'b1, 0);
        drain();
        check("tl_count_rand", WB'(tl_log.size()), WB'(4));
        check_tl(0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
